// File: rtl/screen_fade_sequencer.sv
// Full-screen sprite fade sequencer: latches the screen index, runs fade-in / hold / fade-out
// on frame boundaries and scales the palette RGB by the current brightness level.

module fade_scale (
  input  logic       clk,
  input  logic       rst,
  input  logic       blank,
  input  logic [4:0] level,
  input  logic [3:0] c_in,
  output logic [3:0] c_out
);
  logic [7:0] prod;

  // 15*16 = 240 fits in 8 bits, so level=16 gives an exact pass-through in [7:4]
  assign prod = {4'b0, c_in} * {3'b0, level};

  always_ff @(posedge clk or posedge rst)
    if (rst) c_out <= '0;
    else     c_out <= blank ? prod[7:4] : 4'h0;
endmodule

module screen_fade_sequencer #(
  parameter int FRAMES_PER_STEP = 2,
  parameter int HOLD_FRAMES     = 180,
  parameter int SCREEN_W        = 2
) (
  input  logic                vga_clk,
  input  logic                Reset,
  input  logic                frame_start,
  input  logic                start,
  input  logic [SCREEN_W-1:0] screen_req,
  input  logic                skip,
  input  logic                blank,
  input  logic [3:0]          red_in,
  input  logic [3:0]          green_in,
  input  logic [3:0]          blue_in,
  output logic [SCREEN_W-1:0] screen_sel,
  output logic [4:0]          level,
  output logic [3:0]          red,
  output logic [3:0]          green,
  output logic [3:0]          blue,
  output logic                busy,
  output logic                done
);
  localparam int NUM_CH = 3;
  localparam int CMAX   = (FRAMES_PER_STEP > HOLD_FRAMES) ? FRAMES_PER_STEP : HOLD_FRAMES;
  localparam int CW     = (CMAX < 2) ? 1 : $clog2(CMAX);
  localparam logic [CW-1:0] STEP_LAST = CW'(FRAMES_PER_STEP - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'((HOLD_FRAMES == 0) ? 0 : HOLD_FRAMES - 1);
  localparam logic [4:0]    LVL_MAX   = 5'd16;

  typedef enum logic [1:0] {IDLE, FADE_IN, HOLD, FADE_OUT} state_t;

  state_t                state, state_n;
  logic [4:0]            level_n;
  logic [CW-1:0]         fcnt, fcnt_n;
  logic [SCREEN_W-1:0]   sel_n;
  logic                  done_n;

  always_ff @(posedge vga_clk or posedge Reset)
    if (Reset) begin
      state      <= IDLE;
      level      <= '0;
      fcnt       <= '0;
      screen_sel <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      level      <= level_n;
      fcnt       <= fcnt_n;
      screen_sel <= sel_n;
      done       <= done_n;
    end

  // skip outranks frame_start; start is only honoured from IDLE
  always_comb begin
    state_n = state;
    level_n = level;
    fcnt_n  = fcnt;
    sel_n   = screen_sel;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = FADE_IN;
          sel_n   = screen_req;
          level_n = '0;
          fcnt_n  = '0;
        end
      end
      FADE_IN: begin
        if (skip) begin
          state_n = HOLD;
          level_n = LVL_MAX;
          fcnt_n  = '0;
        end else if (frame_start) begin
          if (fcnt == STEP_LAST) begin
            fcnt_n = '0;
            if (level >= LVL_MAX - 5'd1) begin
              level_n = LVL_MAX;
              state_n = HOLD;
            end else begin
              level_n = level + 5'd1;
            end
          end else begin
            fcnt_n = fcnt + 1'b1;
          end
        end
      end
      HOLD: begin
        level_n = LVL_MAX;
        if (skip) begin
          state_n = FADE_OUT;
          fcnt_n  = '0;
        end else if (frame_start && HOLD_FRAMES != 0) begin
          if (fcnt == HOLD_LAST) begin
            state_n = FADE_OUT;
            fcnt_n  = '0;
          end else begin
            fcnt_n = fcnt + 1'b1;
          end
        end
      end
      FADE_OUT: begin
        if (skip) begin
          state_n = IDLE;
          level_n = '0;
          fcnt_n  = '0;
          done_n  = 1'b1;
        end else if (frame_start) begin
          if (fcnt == STEP_LAST) begin
            fcnt_n = '0;
            if (level <= 5'd1) begin
              level_n = '0;
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              level_n = level - 5'd1;
            end
          end else begin
            fcnt_n = fcnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        level_n = '0;
        fcnt_n  = '0;
      end
    endcase
  end

  assign busy = (state != IDLE);

  logic [NUM_CH-1:0][3:0] rgb_in, rgb_out;
  assign rgb_in = {red_in, green_in, blue_in};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    fade_scale u_ch (
      .clk   (vga_clk),
      .rst   (Reset),
      .blank (blank),
      .level (level),
      .c_in  (rgb_in[g]),
      .c_out (rgb_out[g])
    );
  end

  assign red   = rgb_out[2];
  assign green = rgb_out[1];
  assign blue  = rgb_out[0];
endmodule

// File: tb/tb_screen_fade_sequencer.sv
// Bench for screen_fade_sequencer: fade timing, hold, skip, reset and pixel scaling.
`timescale 1ns/1ps
module tb_screen_fade_sequencer;
  logic       vga_clk = 1'b0;
  logic       Reset;
  logic       frame_start, start, skip, blank;
  logic [1:0] screen_req, screen_sel;
  logic [3:0] red_in, green_in, blue_in, red, green, blue;
  logic [4:0] level;
  logic       busy, done;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  screen_fade_sequencer #(.FRAMES_PER_STEP(2), .HOLD_FRAMES(3), .SCREEN_W(2)) dut (
    .vga_clk(vga_clk), .Reset(Reset), .frame_start(frame_start), .start(start),
    .screen_req(screen_req), .skip(skip), .blank(blank),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .screen_sel(screen_sel), .level(level), .red(red), .green(green), .blue(blue),
    .busy(busy), .done(done)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic tick();
    @(posedge vga_clk); #1;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin pulse_frame(); tick(); end
  endtask

  task automatic do_start(input logic [1:0] req);
    start = 1'b1; screen_req = req; tick(); start = 1'b0;
  endtask

  task automatic do_skip();
    skip = 1'b1; tick(); skip = 1'b0;
  endtask

  function automatic logic [3:0] scale(input logic [3:0] c, input int lvl, input logic bl);
    return bl ? 4'((int'(c) * lvl) / 16) : 4'h0;
  endfunction

  task automatic test_reset();
    Reset = 1'b1; frame_start = 0; start = 0; skip = 0; blank = 0;
    screen_req = 0; red_in = 0; green_in = 0; blue_in = 0;
    #12;
    checks++;
    if ({busy, done, level, screen_sel, red, green, blue} !== 21'd0) begin
      errors++; $display("FAIL reset_state got=%h want=0", {busy, done, level, screen_sel, red, green, blue});
    end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_fade_in();
    do_start(2'd2);
    checks++;
    if ({screen_sel, busy, level} !== {2'd2, 1'b1, 5'd0}) begin
      errors++; $display("FAIL start_latch sel=%0d busy=%0b lvl=%0d want sel=2 busy=1 lvl=0", screen_sel, busy, level);
    end
    for (int k = 1; k <= 32; k++) begin
      frames(1);
      if (k == 1 || k == 2 || k == 17 || k == 31 || k == 32) begin
        checks++;
        if (level !== 5'(k / 2)) begin
          errors++; $display("FAIL fade_in_step k=%0d got=%0d want=%0d", k, level, k / 2);
        end
      end
    end
  endtask

  task automatic test_hold_fade_out();
    frames(2);
    checks++;
    if ({busy, level} !== {1'b1, 5'd16}) begin
      errors++; $display("FAIL hold_level busy=%0b lvl=%0d want busy=1 lvl=16", busy, level);
    end
    frames(1);
    frames(1);
    checks++;
    if (level !== 5'd16) begin errors++; $display("FAIL fade_out_first got=%0d want=16", level); end
    frames(1);
    checks++;
    if (level !== 5'd15) begin errors++; $display("FAIL fade_out_step got=%0d want=15", level); end
    frames(29);
    checks++;
    if ({busy, done, level} !== {1'b1, 1'b0, 5'd1}) begin
      errors++; $display("FAIL fade_out_near busy=%0b done=%0b lvl=%0d want 1/0/1", busy, done, level);
    end
    pulse_frame();
    checks++;
    if ({busy, done, level} !== {1'b0, 1'b1, 5'd0}) begin
      errors++; $display("FAIL fade_out_end busy=%0b done=%0b lvl=%0d want 0/1/0", busy, done, level);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got=%0b want=0", done); end
  endtask

  task automatic run_pixels(input int lvl, input int n, input logic fixed);
    logic [11:0] got, exp;
    logic [3:0] r, g, b;
    for (int i = 0; i < n; i++) begin
      r = fixed ? 4'hF : 4'($urandom_range(0, 15));
      g = fixed ? 4'hA : 4'($urandom_range(0, 15));
      b = fixed ? 4'h3 : 4'($urandom_range(0, 15));
      blank = fixed ? (i == 0) : 1'($urandom_range(0, 1));
      red_in = r; green_in = g; blue_in = b;
      exp_q.push_back({scale(r, lvl, blank), scale(g, lvl, blank), scale(b, lvl, blank)});
      tick();
      got = {red, green, blue};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL pixel_lvl%0d i=%0d got=%h want=%h", lvl, i, got, exp);
      end
    end
  endtask

  task automatic test_pixel();
    do_start(2'd1);
    frames(16);
    checks++;
    if (level !== 5'd8) begin errors++; $display("FAIL pixel_setup got=%0d want=8", level); end
    run_pixels(8, 2, 1'b1);
    run_pixels(8, 6, 1'b0);
    do_skip();
    run_pixels(16, 2, 1'b1);
    run_pixels(16, 6, 1'b0);
    do_skip();
    do_skip();
    run_pixels(0, 4, 1'b0);
    blank = 1'b0;
  endtask

  task automatic test_skip();
    do_start(2'd0);
    frames(10);
    checks++;
    if (level !== 5'd5) begin errors++; $display("FAIL skip_setup got=%0d want=5", level); end
    do_skip();
    checks++;
    if ({busy, level} !== {1'b1, 5'd16}) begin
      errors++; $display("FAIL skip_fade_in busy=%0b lvl=%0d want 1/16", busy, level);
    end
    do_skip();
    frames(2);
    checks++;
    if (level !== 5'd15) begin errors++; $display("FAIL skip_hold got=%0d want=15", level); end
    do_skip();
    checks++;
    if ({busy, done, level} !== {1'b0, 1'b1, 5'd0}) begin
      errors++; $display("FAIL skip_fade_out busy=%0b done=%0b lvl=%0d want 0/1/0", busy, done, level);
    end
    tick();
  endtask

  task automatic test_reset_mid_fade();
    do_start(2'd3);
    frames(14);
    checks++;
    if (level !== 5'd7) begin errors++; $display("FAIL rst_setup got=%0d want=7", level); end
    red_in = 4'hF; green_in = 4'hF; blue_in = 4'hF; blank = 1'b1;
    tick();
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, level, screen_sel, red, green, blue} !== 21'd0) begin
      errors++; $display("FAIL async_reset got=%h want=0", {busy, done, level, screen_sel, red, green, blue});
    end
    #2 Reset = 1'b0;
    blank = 1'b0;
    frames(4);
    checks++;
    if ({busy, level} !== 6'd0) begin
      errors++; $display("FAIL stay_idle busy=%0b lvl=%0d want 0/0", busy, level);
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; skip = 1'b1; screen_req = 2'd1; tick(); start = 1'b0; skip = 1'b0;
    checks++;
    if ({busy, screen_sel} !== {1'b1, 2'd1}) begin
      errors++; $display("FAIL start_over_skip busy=%0b sel=%0d want 1/1", busy, screen_sel);
    end
    do_start(2'd3);
    checks++;
    if (screen_sel !== 2'd1) begin errors++; $display("FAIL start_busy sel=%0d want=1", screen_sel); end
    frames(4);
    skip = 1'b1; frame_start = 1'b1; tick(); skip = 1'b0; frame_start = 1'b0;
    checks++;
    if (level !== 5'd16) begin errors++; $display("FAIL skip_frame got=%0d want=16", level); end
    frames(4);
    checks++;
    if (level !== 5'd16) begin errors++; $display("FAIL skip_frame_hold got=%0d want=16", level); end
    frames(1);
    checks++;
    if (level !== 5'd15) begin errors++; $display("FAIL skip_frame_out got=%0d want=15", level); end
    do_skip();
    tick();
  endtask

  initial begin
    test_reset();
    test_fade_in();
    test_hold_fade_out();
    test_pixel();
    test_skip();
    test_reset_mid_fade();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
